// File: rtl/sparc_windowed_regfile.sv
// SPARC V8 integer register file with overlapping windows, WIM-checked SAVE/RESTORE, trap/RETT window handling,
// plus PSR.icc/ET/CWP, WIM and Y. Reads are registered (latency 1, write-first); window traps pulse one cycle.
module sparc_windowed_regfile #(
    parameter int NWINDOWS = 8,
    parameter int DATA_W   = 32,
    localparam int CWP_W   = (NWINDOWS > 2) ? $clog2(NWINDOWS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [4:0]            rd,
    output logic [DATA_W-1:0]     val1,
    output logic [DATA_W-1:0]     val2,
    output logic [2*DATA_W-1:0]   val3,
    input  logic                  reg_write_en,
    input  logic                  reg_writeDouble_en,
    input  logic [4:0]            wr_reg,
    input  logic [2*DATA_W-1:0]   data,
    input  logic                  save,
    input  logic                  restore,
    input  logic                  trap_enter,
    input  logic                  rett,
    output logic                  win_ovf,
    output logic                  win_unf,
    input  logic                  icc_en,
    input  logic [3:0]            icc_in,
    output logic [3:0]            icc_out,
    input  logic                  Y_en,
    input  logic [DATA_W-1:0]     Y_in,
    output logic [DATA_W-1:0]     Y_out,
    input  logic                  wim_en,
    input  logic [NWINDOWS-1:0]   wim_in,
    output logic [NWINDOWS-1:0]   wim_out,
    output logic [CWP_W-1:0]      cwp_out,
    output logic                  et_out
);
    localparam int NPHYS = 16 * NWINDOWS;
    localparam int PW    = $clog2(NPHYS);
    localparam logic [CWP_W-1:0] CWP_MAX = CWP_W'(NWINDOWS - 1);

    logic [DATA_W-1:0]   g_q [0:7];
    logic [DATA_W-1:0]   w_q [0:NPHYS-1];
    logic [CWP_W-1:0]    cwp_q, cwp_d, cwp_inc, cwp_dec;
    logic                et_q, et_d, ovf_q, ovf_d, unf_q, unf_d;
    logic [NWINDOWS-1:0] wim_q;
    logic [3:0]          icc_q;
    logic [DATA_W-1:0]   y_q;
    logic [DATA_W-1:0]   val1_q, val1_d, val2_q, val2_d;
    logic [2*DATA_W-1:0] val3_q, val3_d;
    logic [4:0]          wlo_addr, whi_addr;
    logic                wlo_en, whi_en;

    // Sum never exceeds 2*NPHYS, so one conditional subtract is a full modulo.
    function automatic logic [PW-1:0] phys_idx(input logic [4:0] a, input logic [CWP_W-1:0] c);
        int s;
        s = int'(a) - 8 + 16 * int'(c);
        if (s >= NPHYS) s = s - NPHYS;
        return s[PW-1:0];
    endfunction

    assign wlo_addr = reg_writeDouble_en ? (wr_reg & ~5'd1) : wr_reg;
    assign whi_addr = wr_reg | 5'd1;
    assign wlo_en   = reg_write_en && (wlo_addr != 5'd0);
    assign whi_en   = reg_write_en && reg_writeDouble_en;

    // g_q[0] is never written, so r0 reads back its reset value of zero.
    function automatic logic [DATA_W-1:0] rd_word(input logic [4:0] a);
        if (whi_en && (a == whi_addr)) return data[2*DATA_W-1:DATA_W];
        if (wlo_en && (a == wlo_addr)) return data[DATA_W-1:0];
        if (a < 5'd8) return g_q[a[2:0]];
        return w_q[phys_idx(a, cwp_q)];
    endfunction

    always_comb begin
        val1_d = rd_word(rs1);
        val2_d = rd_word(rs2);
        val3_d = {rd_word(rd | 5'd1), rd_word(rd & ~5'd1)};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) g_q[i] <= '0;
            for (int i = 0; i < NPHYS; i++) w_q[i] <= '0;
        end else begin
            if (wlo_en) begin
                if (wlo_addr < 5'd8) g_q[wlo_addr[2:0]] <= data[DATA_W-1:0];
                else w_q[phys_idx(wlo_addr, cwp_q)] <= data[DATA_W-1:0];
            end
            if (whi_en) begin
                if (whi_addr < 5'd8) g_q[whi_addr[2:0]] <= data[2*DATA_W-1:DATA_W];
                else w_q[phys_idx(whi_addr, cwp_q)] <= data[2*DATA_W-1:DATA_W];
            end
        end
    end

    assign cwp_inc = (cwp_q == CWP_MAX) ? '0 : cwp_q + 1'b1;
    assign cwp_dec = (cwp_q == '0) ? CWP_MAX : cwp_q - 1'b1;

    always_comb begin
        cwp_d = cwp_q;
        et_d  = et_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (trap_enter) begin
            cwp_d = cwp_dec;
            et_d  = 1'b0;
        end else if (rett) begin
            if (wim_q[cwp_inc]) begin
                unf_d = 1'b1;
            end else begin
                cwp_d = cwp_inc;
                et_d  = 1'b1;
            end
        end else if (save && !restore) begin
            if (wim_q[cwp_dec]) ovf_d = 1'b1;
            else cwp_d = cwp_dec;
        end else if (restore && !save) begin
            if (wim_q[cwp_inc]) unf_d = 1'b1;
            else cwp_d = cwp_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cwp_q  <= '0;
            et_q   <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            wim_q  <= '0;
            icc_q  <= '0;
            y_q    <= '0;
            val1_q <= '0;
            val2_q <= '0;
            val3_q <= '0;
        end else begin
            cwp_q  <= cwp_d;
            et_q   <= et_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            val1_q <= val1_d;
            val2_q <= val2_d;
            val3_q <= val3_d;
            if (wim_en) wim_q <= wim_in;
            if (icc_en) icc_q <= icc_in;
            if (Y_en)   y_q   <= Y_in;
        end
    end

    assign val1    = val1_q;
    assign val2    = val2_q;
    assign val3    = val3_q;
    assign win_ovf = ovf_q;
    assign win_unf = unf_q;
    assign icc_out = icc_q;
    assign Y_out   = y_q;
    assign wim_out = wim_q;
    assign cwp_out = cwp_q;
    assign et_out  = et_q;
endmodule

// File: tb/tb_sparc_windowed_regfile.sv
// Directed bench: one NWINDOWS=8 instance and one NWINDOWS=7 instance share the stimulus.
module tb_sparc_windowed_regfile;
    logic        clk = 1'b0, reset = 1'b0;
    logic [4:0]  rs1, rs2, rd, wr_reg;
    logic        reg_write_en, reg_writeDouble_en;
    logic [63:0] data;
    logic        save, restore, trap_enter, rett, icc_en, Y_en, wim_en;
    logic [3:0]  icc_in;
    logic [31:0] Y_in;
    logic [7:0]  wim_in;

    logic [31:0] val1_a, val2_a, y_a, val1_b, val2_b, y_b;
    logic [63:0] val3_a, val3_b;
    logic        ovf_a, unf_a, et_a, ovf_b, unf_b, et_b;
    logic [3:0]  icc_a, icc_b;
    logic [7:0]  wim_a;
    logic [6:0]  wim_b;
    logic [2:0]  cwp_a, cwp_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sparc_windowed_regfile #(.NWINDOWS(8), .DATA_W(32)) dut_a (
        .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd),
        .val1(val1_a), .val2(val2_a), .val3(val3_a),
        .reg_write_en(reg_write_en), .reg_writeDouble_en(reg_writeDouble_en),
        .wr_reg(wr_reg), .data(data), .save(save), .restore(restore),
        .trap_enter(trap_enter), .rett(rett), .win_ovf(ovf_a), .win_unf(unf_a),
        .icc_en(icc_en), .icc_in(icc_in), .icc_out(icc_a),
        .Y_en(Y_en), .Y_in(Y_in), .Y_out(y_a),
        .wim_en(wim_en), .wim_in(wim_in), .wim_out(wim_a),
        .cwp_out(cwp_a), .et_out(et_a)
    );

    sparc_windowed_regfile #(.NWINDOWS(7), .DATA_W(32)) dut_b (
        .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd),
        .val1(val1_b), .val2(val2_b), .val3(val3_b),
        .reg_write_en(reg_write_en), .reg_writeDouble_en(reg_writeDouble_en),
        .wr_reg(wr_reg), .data(data), .save(save), .restore(restore),
        .trap_enter(trap_enter), .rett(rett), .win_ovf(ovf_b), .win_unf(unf_b),
        .icc_en(icc_en), .icc_in(icc_in), .icc_out(icc_b),
        .Y_en(Y_en), .Y_in(Y_in), .Y_out(y_b),
        .wim_en(wim_en), .wim_in(wim_in[6:0]), .wim_out(wim_b),
        .cwp_out(cwp_b), .et_out(et_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rs1 = 0; rs2 = 0; rd = 0; wr_reg = 0; data = '0;
        reg_write_en = 0; reg_writeDouble_en = 0;
        save = 0; restore = 0; trap_enter = 0; rett = 0;
        icc_en = 0; icc_in = 0; Y_en = 0; Y_in = 0; wim_en = 0; wim_in = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] d, input logic dbl);
        reg_write_en = 1; reg_writeDouble_en = dbl; wr_reg = a; data = d;
    endtask

    initial begin
        idle();
        #2 reset = 1;
        #1;
        chk("rst_cwp", cwp_a, 0);
        chk("rst_et", et_a, 0);
        chk("rst_val3", val3_a, 0);
        tick(); tick();
        reset = 0;

        // Reach CWP=3 with WIM=0x10, then reset in the middle of a save.
        wim_en = 1; wim_in = 8'h10; tick(); idle();
        chk("wim_wr", wim_a, 8'h10);
        restore = 1; tick(); tick(); tick(); idle();
        chk("cwp_3", cwp_a, 3);
        save = 1; wr(9, 64'h99, 0); rs1 = 9; rd = 8;
        #2 reset = 1;
        #1;
        chk("midrst_cwp", cwp_a, 0);
        chk("midrst_wim", wim_a, 0);
        chk("midrst_val1", val1_a, 0);
        chk("midrst_val2", val2_a, 0);
        chk("midrst_val3", val3_a, 0);
        chk("midrst_ovf", ovf_a, 0);
        idle(); tick(); reset = 0;
        rs1 = 9; tick(); idle();
        chk("midrst_r9", val1_a, 0);

        // Outs of window 0 become ins of window 7 after a save.
        wr(8, 64'hDEADBEEF, 0); tick(); idle();
        save = 1; tick(); idle();
        chk("save_cwp7", cwp_a, 7);
        chk("save_cwp6_n7", cwp_b, 6);
        rs1 = 24; tick(); idle();
        chk("overlap_a", val1_a, 32'hDEADBEEF);
        chk("overlap_b", val1_b, 32'hDEADBEEF);
        restore = 1; tick(); idle();
        chk("restore_wrap_a", cwp_a, 0);
        chk("restore_wrap_b", cwp_b, 0);

        // Overflow at CWP=0 with WIM[7] set; back-to-back requests pulse twice.
        wim_en = 1; wim_in = 8'h80; tick(); idle();
        save = 1; tick();
        chk("ovf_1", ovf_a, 1);
        chk("ovf_cwp", cwp_a, 0);
        tick(); idle();
        chk("ovf_2", ovf_a, 1);
        tick();
        chk("ovf_drop", ovf_a, 0);
        trap_enter = 1; tick(); idle();
        chk("trap_cwp", cwp_a, 7);
        chk("trap_et", et_a, 0);
        rett = 1; tick(); idle();
        chk("rett_cwp", cwp_a, 0);
        chk("rett_et", et_a, 1);

        // Underflow: CWP=1, WIM[2] set.
        wim_en = 1; wim_in = 8'h04; tick(); idle();
        restore = 1; tick();
        chk("restore_ok", cwp_a, 1);
        tick(); idle();
        chk("unf", unf_a, 1);
        chk("unf_cwp", cwp_a, 1);
        wim_en = 1; wim_in = 8'h00; tick(); idle();
        restore = 1; tick(); idle();
        chk("cwp_2", cwp_a, 2);

        // Globals are not windowed; r0 stays zero. icc/Y ride along with a save.
        wr(0, 64'h5, 0); tick(); idle();
        wr(3, 64'h1234, 0); tick(); idle();
        save = 1; icc_en = 1; icc_in = 4'hA; Y_en = 1; Y_in = 32'hCAFEF00D; tick(); idle();
        chk("save_cwp1", cwp_a, 1);
        chk("icc", icc_a, 4'hA);
        chk("y", y_a, 32'hCAFEF00D);
        rs1 = 0; rs2 = 3; tick(); idle();
        chk("r0_zero", val1_a, 0);
        chk("global_r3", val2_a, 32'h1234);

        // Double writes and write-first bypass.
        wr(16, 64'h11112222_33334444, 1); rd = 16; tick(); idle();
        chk("dbl_bypass", val3_a, 64'h11112222_33334444);
        rs1 = 17; rs2 = 16; tick(); idle();
        chk("dbl_hi", val1_a, 32'h11112222);
        chk("dbl_lo", val2_a, 32'h33334444);
        wr(5, 64'h77, 0); rs1 = 5; tick(); idle();
        chk("single_bypass", val1_a, 32'h77);
        wr(7, 64'hAAAA0007_BBBB0006, 1); tick(); idle();
        rd = 7; tick(); idle();
        chk("dbl_r6r7", val3_a, 64'hAAAA0007_BBBB0006);
        wr(1, 64'hCCCC0001_DDDD0000, 1); tick(); idle();
        rd = 1; tick(); idle();
        chk("dbl_r0r1", val3_a, 64'hCCCC0001_00000000);

        // Ins of window 1 are outs of window 2.
        wr(24, 64'h5555, 0); tick(); idle();
        restore = 1; tick(); idle();
        rs1 = 8; tick(); idle();
        chk("ins_outs", val1_a, 32'h5555);

        // NWINDOWS=7 explicit modulo wrap; save+restore together is a no-op.
        reset = 1; tick(); reset = 0;
        trap_enter = 1; tick(); idle();
        chk("n7_dec_wrap", cwp_b, 6);
        chk("n8_dec_wrap", cwp_a, 7);
        restore = 1; tick(); idle();
        chk("n7_inc_wrap", cwp_b, 0);
        save = 1; restore = 1; tick(); idle();
        chk("n7_both_cwp", cwp_b, 0);
        chk("n7_both_trap", {ovf_b, unf_b}, 0);
        chk("n8_both_trap", {ovf_a, unf_a}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sparc_windowed_regfile.md
Name: sparc_windowed_regfile

Overview:
- Parametrised SPARC V8 integer register file with true overlapping register windows, WIM-checked SAVE/RESTORE, and trap-entry/RETT window handling.
- Also holds PSR.icc, PSR.ET, PSR.CWP, WIM and Y.
- Sits between decode (read ports) and writeback (write port) in the integer pipeline.
- Raises window overflow/underflow indications to the trap logic.

Parameters:
- NWINDOWS, 8, number of register windows (2..32; need not be a power of 2).
- DATA_W, 32, word width.
- CWP_W, $clog2(NWINDOWS) (localparam, min 1), CWP width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rs1, rs2  in  5  architectural read addresses
- rd  in  5  double-read address; bit 0 ignored
- val1, val2  out  DATA_W  read data for rs1/rs2
- val3  out  2*DATA_W  {r[rd|1], r[rd&~1]}
- reg_write_en  in  1  write strobe
- reg_writeDouble_en  in  1  write register pair
- wr_reg  in  5  write address
- data  in  2*DATA_W  write data; low word to wr_reg, high word to pair partner
- save, restore  in  1  window op requests
- trap_enter  in  1  trap entry
- rett  in  1  return from trap
- win_ovf, win_unf  out  1  one-cycle trap indications
- icc_en  in  1  PSR.icc write enable
- icc_in  in  4  PSR.icc write data
- icc_out  out  4  PSR.icc
- Y_en  in  1  Y write enable
- Y_in  in  DATA_W  Y write data
- Y_out  out  DATA_W  Y
- wim_en  in  1  WIM write enable
- wim_in  in  NWINDOWS  WIM write data
- wim_out  out  NWINDOWS  WIM
- cwp_out  out  CWP_W  current window pointer
- et_out  out  1  PSR.ET

Behaviour:
- **Storage:** 8 globals plus 16*NWINDOWS windowed words.
  - Physical index for r in 8..31 is ((r-8) + 16*CWP) mod (16*NWINDOWS).
  - So the ins of window w are the outs of window (w+1) mod NWINDOWS.
  - r0 always reads 0; writes to r0 are discarded.
- **Reset (async, active-high):** clears all registers, CWP, WIM, Y, icc, ET, win_ovf/win_unf and val1/val2/val3. Reset mid-operation aborts any pending op with no partial update.
- **Writes (posedge):**
  - When reg_write_en is set, data[DATA_W-1:0] goes to wr_reg.
  - When reg_writeDouble_en is also set, data[2*DATA_W-1:DATA_W] goes to the partner: wr_reg with bit 0 cleared for the low word, bit 0 set for the high word.
  - A double write to the r0/r1 pair still writes r1.
  - A double write to r7 pairs r6/r7. Pairs never straddle globals/windowed.
- **Reads:** registered, latency 1.
  - Addresses sampled at posedge N; outputs valid after posedge N.
  - Write-first: a same-cycle write to a read address is forwarded (word- and half-granular for val3).
- **CWP used in cycle N:**
  - Read and write address mapping use the CWP value before any window update in that cycle.
  - The new CWP affects cycle N+1.
- **Window ops (posedge), priority trap_enter > rett > save/restore:**
  - trap_enter:
    - CWP <= (CWP-1) mod NWINDOWS with no WIM check; ET <= 0.
    - Any simultaneous rett/save/restore is ignored.
  - rett:
    - If WIM[(CWP+1) mod N], win_unf=1 and CWP and ET are unchanged.
    - Otherwise CWP <= (CWP+1) mod N and ET <= 1.
  - save:
    - If WIM[(CWP-1) mod N], win_ovf=1 and CWP is unchanged.
    - Otherwise CWP decrements.
  - restore:
    - If WIM[(CWP+1) mod N], win_unf=1 and CWP is unchanged.
    - Otherwise CWP increments.
  - save and restore asserted together: no action, no trap.
- **Wrap-around:** arithmetic is explicit modulo NWINDOWS, not bit truncation (e.g. NWINDOWS=7, CWP=6 +1 -> 0; CWP=0 -1 -> 6).
- **win_ovf/win_unf:** registered, high exactly one cycle per offending request; back-to-back requests give back-to-back pulses.
- **WIM:** wim_en writes WIM at posedge. The WIM check in the same cycle uses the old WIM.
- **icc and Y:** icc_en and Y_en are independent and may coincide with any other op.
- **Outputs:** icc_out, Y_out, wim_out, cwp_out and et_out reflect the registered state, with no extra latency.

Test Plan:
- Assert reset mid-save with CWP=3, WIM=0x10 -> immediately cwp_out=0, wim_out=0, val1/val2/val3=0, win_ovf=0.
- NWINDOWS=8, CWP=0, write r8=0xDEADBEEF, save, then read rs1=24 -> cwp_out=7, val1=0xDEADBEEF one cycle after the rs1 sample.
- wim_in=0x80 written, CWP=0, save -> win_ovf=1 for one cycle, cwp_out stays 0. Then trap_enter -> cwp_out=7, et_out=0. Then rett -> cwp_out=0, et_out=1.
- Write r0=5 and r3=0x1234 at CWP=2, then save; read rs1=0, rs2=3 -> val1=0, val2=0x1234 (globals not windowed).
- reg_writeDouble_en to wr_reg=16 with data=0x11112222_33334444, rd=16 sampled the same cycle -> val3=0x11112222_33334444 via bypass; later rs1=17 -> 0x11112222.
- NWINDOWS=7, WIM=0, CWP=6, restore -> cwp_out=0. Then save and restore together -> cwp_out=0, no win_ovf/win_unf pulse.
